// File: rtl/vram_plane_ctrl.sv
// Banked bitplane VRAM for the Z80 bus: CPU window with read-plane select and broadcast write
// mask, a free-running video fetch port, and a background plane-fill engine.
//
// state  | meaning
// S_IDLE | fill engine parked, waiting for a FILL_PORT write edge
// S_RUN  | writing fill_byte to fill_mask planes, yielding to any CPU memory cycle
module vram_plane_ctrl #(
    parameter int         PLANES    = 6,
    parameter int         ADDR_W    = 13,
    parameter logic [7:0] RD_PORT   = 8'hF1,
    parameter logic [7:0] WR_PORT   = 8'hF2,
    parameter logic [7:0] FILL_PORT = 8'hF3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_sel,
    input  logic [7:0]            io_addr,
    input  logic                  io_wr_n,
    input  logic [7:0]            io_din,
    output logic [7:0]            io_q,
    input  logic                  mem_sel,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_wr_n,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_q,
    input  logic [ADDR_W-1:0]     vaddr,
    output logic [8*PLANES-1:0]   vdata,
    output logic                  fill_busy,
    output logic                  fill_done
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    fill_addr_q, fill_addr_d;
    logic [7:0]           fill_byte_q, fill_byte_d;
    logic [PLANES-1:0]    fill_mask_q, fill_mask_d;
    logic                 fill_done_q, fill_done_d;
    logic                 fill_we;
    logic                 strobe_q;
    logic [7:0]           rd_sel_q, wr_mask_q;
    logic [7:0]           io_q_q, mem_q_q;
    logic [8*PLANES-1:0]  vdata_q, vdata_d;
    logic [7:0]           plane_ram [PLANES][DEPTH];

    logic                 io_wr, io_rd, cpu_wr, cpu_rd, fill_strobe;
    logic [PLANES-1:0]    we_mask;
    logic [ADDR_W-1:0]    waddr;
    logic [7:0]           wdata;
    logic [7:0]           io_rd_data, cpu_rd_data;

    assign io_wr       = io_sel & ~io_wr_n;
    assign io_rd       = io_sel & io_wr_n;
    assign cpu_wr      = mem_sel & ~mem_wr_n;
    assign cpu_rd      = mem_sel & mem_wr_n;
    assign fill_strobe = io_wr && (io_addr == FILL_PORT);

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        fill_byte_d = fill_byte_q;
        fill_mask_d = fill_mask_q;
        fill_done_d = 1'b0;
        fill_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fill_strobe && !strobe_q) begin
                    state_d     = S_RUN;
                    fill_byte_d = io_din;
                    fill_mask_d = wr_mask_q[PLANES-1:0];
                    fill_addr_d = '0;
                end
            end
            S_RUN: begin
                if (!mem_sel) begin
                    fill_we = 1'b1;
                    if (fill_addr_q == LAST_ADDR) begin
                        state_d     = S_IDLE;
                        fill_done_d = 1'b1;
                    end else begin
                        fill_addr_d = fill_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CPU and fill never write in the same cycle: the fill only runs when mem_sel is low.
    always_comb begin
        we_mask = '0;
        waddr   = fill_addr_q;
        wdata   = fill_byte_q;
        if (cpu_wr) begin
            we_mask = wr_mask_q[PLANES-1:0];
            waddr   = mem_addr;
            wdata   = mem_din;
        end else if (fill_we) begin
            we_mask = fill_mask_q;
        end
        if (reset) we_mask = '0;
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < PLANES; p++) begin
            if (we_mask[p]) plane_ram[p][waddr] <= wdata;
        end
    end

    always_comb begin
        cpu_rd_data = 8'h00;
        vdata_d     = '0;
        for (int p = 0; p < PLANES; p++) begin
            if (rd_sel_q == 8'(p + 1)) cpu_rd_data = plane_ram[p][mem_addr];
            vdata_d[8*p +: 8] = plane_ram[p][vaddr];
        end
    end

    always_comb begin
        io_rd_data = 8'hFF;
        if (io_rd) begin
            case (io_addr)
                RD_PORT:   io_rd_data = rd_sel_q;
                WR_PORT:   io_rd_data = wr_mask_q;
                FILL_PORT: io_rd_data = {7'b0, state_q == S_RUN};
                default:   io_rd_data = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fill_addr_q <= '0;
            fill_byte_q <= 8'h00;
            fill_mask_q <= '0;
            fill_done_q <= 1'b0;
            strobe_q    <= 1'b0;
            rd_sel_q    <= 8'h00;
            wr_mask_q   <= 8'h00;
            io_q_q      <= 8'hFF;
            mem_q_q     <= 8'h00;
            vdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            fill_byte_q <= fill_byte_d;
            fill_mask_q <= fill_mask_d;
            fill_done_q <= fill_done_d;
            strobe_q    <= fill_strobe;
            if (io_wr && (io_addr == RD_PORT)) rd_sel_q  <= io_din;
            if (io_wr && (io_addr == WR_PORT)) wr_mask_q <= io_din;
            io_q_q      <= io_rd_data;
            if (cpu_rd) mem_q_q <= cpu_rd_data;
            vdata_q     <= vdata_d;
        end
    end

    assign io_q      = io_q_q;
    assign mem_q     = mem_q_q;
    assign vdata     = vdata_q;
    assign fill_busy = (state_q == S_RUN);
    assign fill_done = fill_done_q;

endmodule

// File: tb/tb_vram_plane_ctrl.sv
// Directed bench for vram_plane_ctrl: expectations queued as stimulus is driven, popped and
// asserted when the DUT output is sampled one cycle later.
module tb_vram_plane_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_sel, io_wr_n;
    logic [7:0]  io_addr, io_din, io_q;
    logic        mem_sel, mem_wr_n;
    logic [12:0] mem_addr, vaddr;
    logic [7:0]  mem_din, mem_q;
    logic [47:0] vdata;
    logic        fill_busy, fill_done;

    vram_plane_ctrl dut (
        .clk(clk), .reset(reset),
        .io_sel(io_sel), .io_addr(io_addr), .io_wr_n(io_wr_n), .io_din(io_din), .io_q(io_q),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wr_n(mem_wr_n), .mem_din(mem_din),
        .mem_q(mem_q), .vaddr(vaddr), .vdata(vdata),
        .fill_busy(fill_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cnt, dones;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        io_sel = 1'b1; io_wr_n = 1'b0; io_addr = a; io_din = d;
        step();
        io_sel = 1'b0; io_wr_n = 1'b1;
    endtask

    task automatic io_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        io_sel = 1'b1; io_wr_n = 1'b1; io_addr = a;
        expect_v(tag, 64'(exp));
        step();
        io_sel = 1'b0;
        check(64'(io_q));
    endtask

    task automatic mem_write(input logic [12:0] a, input logic [7:0] d);
        mem_sel = 1'b1; mem_wr_n = 1'b0; mem_addr = a; mem_din = d;
        step();
        mem_sel = 1'b0; mem_wr_n = 1'b1;
    endtask

    task automatic mem_read(input logic [12:0] a, input logic [7:0] exp, input string tag);
        mem_sel = 1'b1; mem_wr_n = 1'b1; mem_addr = a;
        expect_v(tag, 64'(exp));
        step();
        mem_sel = 1'b0;
        check(64'(mem_q));
    endtask

    initial begin
        reset = 1'b1; io_sel = 1'b0; io_addr = 8'h00; io_wr_n = 1'b1; io_din = 8'h00;
        mem_sel = 1'b0; mem_addr = '0; mem_wr_n = 1'b1; mem_din = 8'h00; vaddr = '0;
        repeat (3) step();
        expect_v("rst_io_q", 64'hFF);   check(64'(io_q));
        expect_v("rst_mem_q", 64'h00);  check(64'(mem_q));
        expect_v("rst_vdata", 64'h0);   check(64'(vdata));
        expect_v("rst_busy", 64'h0);    check(64'(fill_busy));
        expect_v("rst_done", 64'h0);    check(64'(fill_done));
        reset = 1'b0;

        io_read(8'hF1, 8'h00, "rst_rd_sel");
        io_read(8'hF2, 8'h00, "rst_wr_mask");
        io_read(8'hF3, 8'h00, "rst_status");
        io_read(8'hF0, 8'hFF, "other_port");
        mem_read(13'h123, 8'h00, "rd_sel0");

        // broadcast write to planes 0 and 2, plane 1 keeps its own byte
        io_write(8'hF2, 8'h02); mem_write(13'h123, 8'h3C);
        io_write(8'hF2, 8'h05); mem_write(13'h123, 8'hA5);
        io_write(8'hF1, 8'd1);  mem_read(13'h123, 8'hA5, "bcast_p0");
        io_write(8'hF1, 8'd2);  mem_read(13'h123, 8'h3C, "bcast_p1_untouched");
        io_write(8'hF1, 8'd3);  mem_read(13'h123, 8'hA5, "bcast_p2");
        io_write(8'hF2, 8'h00); mem_write(13'h123, 8'h99);
        expect_v("mem_q_hold_on_write", 64'hA5); check(64'(mem_q));
        mem_read(13'h123, 8'hA5, "mask0_drops_write");
        vaddr = 13'h123; step();
        expect_v("vdata_p0", 64'hA5); check(64'(vdata[7:0]));
        expect_v("vdata_p1", 64'h3C); check(64'(vdata[15:8]));
        expect_v("vdata_p2", 64'hA5); check(64'(vdata[23:16]));

        io_write(8'hF2, 8'h20); mem_write(13'h124, 8'h77);
        io_write(8'hF1, 8'd6);  mem_read(13'h124, 8'h77, "plane6_read");
        io_write(8'hF1, 8'd7);  mem_read(13'h124, 8'h00, "rd_sel_over");
        io_write(8'hF2, 8'hC0); io_read(8'hF2, 8'hC0, "mask_high_stored");
        mem_write(13'h124, 8'h99);
        io_write(8'hF1, 8'd6);  mem_read(13'h124, 8'h77, "mask_high_no_effect");

        // full clear with no CPU traffic
        io_write(8'hF2, 8'h3F); mem_write(13'h1000, 8'h3C); mem_write(13'h1FFF, 8'hEE);
        vaddr = 13'h1000;
        io_write(8'hF3, 8'h00);
        cnt = 0; dones = 0;
        while (fill_busy === 1'b1 && cnt < 20000) begin
            cnt++;
            if (cnt == 10) begin
                expect_v("vdata_during_fill_p0", 64'h3C); check(64'(vdata[7:0]));
                expect_v("vdata_during_fill_p5", 64'h3C); check(64'(vdata[47:40]));
            end
            if (fill_done === 1'b1) dones++;
            step();
        end
        expect_v("fill_cycles", 64'd8192); check(64'(cnt));
        expect_v("done_inside_busy", 64'd0); check(64'(dones));
        expect_v("done_pulse", 64'h1); check(64'(fill_done));
        step();
        expect_v("done_one_cycle", 64'h0); check(64'(fill_done));
        expect_v("vdata_after_fill", 64'h0); check(64'(vdata));
        for (int p = 1; p <= 6; p++) begin
            io_write(8'hF1, 8'(p));
            mem_read(13'h1FFF, 8'h00, "clear_last");
            mem_read(13'h0123, 8'h00, "clear_mid");
        end

        // fill with 100 CPU cycles stealing slots, one of them a write into the tail
        io_write(8'hF2, 8'h03);
        io_write(8'hF3, 8'h5A);
        cnt = 0;
        while (fill_busy === 1'b1 && cnt < 20000) begin
            cnt++;
            mem_sel  = (cnt >= 100 && cnt < 200);
            mem_wr_n = (cnt != 100);
            mem_addr = 13'h1FFF;
            mem_din  = 8'hEE;
            step();
        end
        mem_sel = 1'b0; mem_wr_n = 1'b1;
        expect_v("stalled_fill_cycles", 64'd8292); check(64'(cnt));
        expect_v("stalled_done", 64'h1); check(64'(fill_done));
        io_write(8'hF1, 8'd1); mem_read(13'h1FFF, 8'h5A, "fill_overwrites_cpu_p0");
        io_write(8'hF1, 8'd2); mem_read(13'h1FFF, 8'h5A, "fill_overwrites_cpu_p1");
        io_write(8'hF1, 8'd3); mem_read(13'h1FFF, 8'h00, "fill_mask_excl_p2");

        // fill-port write and mask change mid-run are ignored; reset aborts at 0x800
        io_write(8'hF2, 8'h3F);
        io_write(8'hF3, 8'h11);
        cnt = 0;
        while (fill_busy === 1'b1 && cnt < 20000) begin
            cnt++;
            io_sel = 1'b0; io_wr_n = 1'b1;
            if (cnt == 10) begin io_sel = 1'b1; io_wr_n = 1'b0; io_addr = 8'hF3; io_din = 8'h55; end
            if (cnt == 11) begin io_sel = 1'b1; io_wr_n = 1'b0; io_addr = 8'hF2; io_din = 8'h01; end
            if (cnt == 12) begin io_sel = 1'b1; io_wr_n = 1'b1; io_addr = 8'hF3; expect_v("status_busy", 64'h1); end
            if (cnt == 13) check(64'(io_q));
            if (cnt == 13'h801) reset = 1'b1;
            step();
        end
        io_sel = 1'b0; io_wr_n = 1'b1;
        expect_v("abort_cycle", 64'h801); check(64'(cnt));
        expect_v("abort_busy", 64'h0); check(64'(fill_busy));
        expect_v("abort_no_done", 64'h0); check(64'(fill_done));
        reset = 1'b0;
        step();
        io_read(8'hF2, 8'h00, "mask_after_reset");
        io_read(8'hF1, 8'h00, "rdsel_after_reset");
        io_write(8'hF1, 8'd1); mem_read(13'h7FF, 8'h11, "abort_last_filled_p0");
        mem_read(13'h800, 8'h5A, "abort_untouched_p0");
        io_write(8'hF1, 8'd6); mem_read(13'h7FF, 8'h11, "orig_mask_p5");
        mem_read(13'h800, 8'h00, "abort_untouched_p5");
        io_write(8'hF1, 8'd2); mem_read(13'h000, 8'h11, "orig_byte_p1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
